// File: rtl/uart_pkg.sv
// Shared UART definitions: receive-side state encoding and the frame data width
// that the future TX framer will also use.
package uart_pkg;

    localparam int unsigned UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchroniser for asynchronous inputs; both flops load
// RESET_VALUE under synchronous reset so the output is a known level immediately.
module sync_2ff #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RESET_VALUE;
            q    <= RESET_VALUE;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_deframer.sv
// 8N1 serial receiver front end: synchronises the line, rejects false starts,
// samples data mid-bit and reports good bytes, framing errors and overruns.
module uart_rx_deframer
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_serial_in,
    input  logic       fifo_full,
    output logic [7:0] rx_data,
    output logic       rx_wr_en,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned HALF  = CLKS_PER_BIT / 2;

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       IDX_LAST  = 3'(UART_DATA_BITS - 1);

    logic                      rx_s;
    rx_state_t                 state;
    logic [CNT_W-1:0]          cnt;
    logic [2:0]                idx;
    logic [UART_DATA_BITS-1:0] sh;

    sync_2ff #(
        .RESET_VALUE(1'b1)
    ) u_rx_sync (
        .clk(clk),
        .rst(rst),
        .d  (rx_serial_in),
        .q  (rx_s)
    );

    // busy is registered alongside the state so it tracks "state != IDLE" exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            sh        <= '0;
            rx_data   <= '0;
            rx_wr_en  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            rx_wr_en  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;

            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end

                START: begin
                    if (cnt == HALF_LAST) begin
                        if (!rx_s) begin
                            state <= DATA;
                            cnt   <= '0;
                            idx   <= '0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        sh  <= {rx_s, sh[UART_DATA_BITS-1:1]};
                        if (idx == IDX_LAST) begin
                            state <= STOP;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        if (rx_s) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            if (fifo_full) begin
                                overrun <= 1'b1;
                            end else begin
                                rx_data  <= sh;
                                rx_wr_en <= 1'b1;
                            end
                        end else begin
                            state     <= BREAK;
                            frame_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                BREAK: begin
                    // A held-low line stays here, so only one frame_err is reported.
                    if (rx_s) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Bench for uart_rx_deframer: directed frames from the test plan plus random
// traffic, checked every cycle against a sample-point model of 8N1 reception.
module tb_uart_rx_deframer;

    localparam int CPB  = 16;
    localparam int HALF = CPB / 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       line = 1'b1;
    logic       fifo_full = 1'b0;
    logic [7:0] rx_data;
    logic       rx_wr_en;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    uart_rx_deframer #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_serial_in(line),
        .fifo_full   (fifo_full),
        .rx_data     (rx_data),
        .rx_wr_en    (rx_wr_en),
        .frame_err   (frame_err),
        .overrun     (overrun),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Reference: line delayed two cycles, then decisions at fixed offsets from
    // the cycle e where the delayed line first reads low.
    logic       m_d1 = 1'b1;
    logic       m_d2 = 1'b1;
    int         m_mode = 0;      // 0 waiting for start, 1 in frame, 2 waiting for line high
    int         m_e = 0;
    logic [7:0] m_bits = '0;
    logic [7:0] m_data = '0;
    logic       m_wr = 1'b0;
    logic       m_fe = 1'b0;
    logic       m_ov = 1'b0;

    int         ev_cyc[$];
    int         ev_kind[$];     // 0 write, 1 frame error, 2 overrun
    int         ev_data[$];

    task automatic model_step();
        logic rxs;
        int   d;
        int   k;
        rxs  = m_d2;
        m_d2 = rst ? 1'b1 : m_d1;
        m_d1 = rst ? 1'b1 : line;
        m_wr = 1'b0;
        m_fe = 1'b0;
        m_ov = 1'b0;
        if (rst) begin
            m_mode = 0;
            m_data = '0;
        end else if (m_mode == 0) begin
            if (!rxs) begin
                m_mode = 1;
                m_e    = cyc;
            end
        end else if (m_mode == 1) begin
            d = cyc - m_e;
            if (d == HALF) begin
                if (rxs) m_mode = 0;
            end else if (d > HALF && (d - HALF) % CPB == 0) begin
                k = (d - HALF) / CPB - 1;
                if (k < 8) begin
                    m_bits[k] = rxs;
                end else if (rxs) begin
                    m_mode = 0;
                    if (fifo_full) begin
                        m_ov = 1'b1;
                    end else begin
                        m_wr   = 1'b1;
                        m_data = m_bits;
                    end
                end else begin
                    m_fe   = 1'b1;
                    m_mode = 2;
                end
            end
        end else begin
            if (rxs) m_mode = 0;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
            cyc++;
            @(negedge clk);
            n_cmp++;
            if (rx_data !== m_data || rx_wr_en !== m_wr || frame_err !== m_fe ||
                overrun !== m_ov || busy !== (m_mode != 0)) begin
                n_bad++;
                $display("FAIL cycle %0d outputs: got data=%h wr=%b fe=%b ov=%b busy=%b, want data=%h wr=%b fe=%b ov=%b busy=%b",
                         cyc, rx_data, rx_wr_en, frame_err, overrun, busy,
                         m_data, m_wr, m_fe, m_ov, (m_mode != 0));
            end
            if (rx_wr_en === 1'b1) begin ev_cyc.push_back(cyc); ev_kind.push_back(0); ev_data.push_back(int'(rx_data)); end
            if (frame_err === 1'b1) begin ev_cyc.push_back(cyc); ev_kind.push_back(1); ev_data.push_back(0); end
            if (overrun === 1'b1) begin ev_cyc.push_back(cyc); ev_kind.push_back(2); ev_data.push_back(0); end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic int count_kind(input int from, input int kind);
        int n = 0;
        for (int i = from; i < ev_kind.size(); i++)
            if (ev_kind[i] == kind) n++;
        return n;
    endfunction

    // Returns cycle (sel=0) or data (sel=1) of the nth event of a kind, -1 if absent.
    function automatic int nth_ev(input int from, input int kind, input int n, input int sel);
        int seen = 0;
        for (int i = from; i < ev_kind.size(); i++) begin
            if (ev_kind[i] == kind) begin
                if (seen == n) return (sel == 0) ? ev_cyc[i] : ev_data[i];
                seen++;
            end
        end
        return -1;
    endfunction

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_bit(input logic b);
        line = b;
        wait_cycles(CPB);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, output int r);
        r = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop);
    endtask

    int s, s2, r, r0, r1, r2;

    initial begin
        wait_cycles(3);
        check("reset rx_data", int'(rx_data), 0);
        check("reset strobes", int'({rx_wr_en, frame_err, overrun}), 0);
        check("reset busy", int'(busy), 0);
        rst = 1'b0;
        wait_cycles(5);

        // Single frame 0xA5
        s = ev_cyc.size();
        send_frame(8'hA5, 1'b1, r);
        wait_cycles(20);
        check("a5 write count", count_kind(s, 0), 1);
        check("a5 write cycle", nth_ev(s, 0, 0, 0), r + 155);
        check("a5 data", nth_ev(s, 0, 0, 1), 'hA5);
        check("a5 error count", count_kind(s, 1) + count_kind(s, 2), 0);

        // Back-to-back frames
        s = ev_cyc.size();
        send_frame(8'h00, 1'b1, r0);
        send_frame(8'hFF, 1'b1, r1);
        send_frame(8'h3C, 1'b1, r2);
        wait_cycles(20);
        check("b2b write count", count_kind(s, 0), 3);
        check("b2b data0", nth_ev(s, 0, 0, 1), 'h00);
        check("b2b data1", nth_ev(s, 0, 1, 1), 'hFF);
        check("b2b data2", nth_ev(s, 0, 2, 1), 'h3C);
        check("b2b cycle2", nth_ev(s, 0, 2, 0), r0 + 475);

        // Glitch: 6 cycles low
        s = ev_cyc.size();
        r = cyc;
        line = 1'b0;
        wait_cycles(6);
        line = 1'b1;
        check("glitch busy mid", int'(busy), 1);
        wait_cycles(5);
        check("glitch busy cleared", int'(busy), 0);
        wait_cycles(20);
        check("glitch no events", ev_cyc.size() - s, 0);
        send_frame(8'h55, 1'b1, r);
        wait_cycles(20);
        check("after glitch data", nth_ev(s, 0, 0, 1), 'h55);

        // Bad stop bit, then long break
        s = ev_cyc.size();
        send_frame(8'h81, 1'b0, r);
        wait_cycles(40 * CPB);
        line = 1'b1;
        wait_cycles(30);
        check("break fe count", count_kind(s, 1), 1);
        check("break fe cycle", nth_ev(s, 1, 0, 0), r + 155);
        check("break write count", count_kind(s, 0), 0);
        s2 = ev_cyc.size();
        send_frame(8'h42, 1'b1, r);
        wait_cycles(20);
        check("after break data", nth_ev(s2, 0, 0, 1), 'h42);

        // Overrun while FIFO full
        s = ev_cyc.size();
        fifo_full = 1'b1;
        send_frame(8'h7E, 1'b1, r);
        wait_cycles(20);
        fifo_full = 1'b0;
        check("overrun count", count_kind(s, 2), 1);
        check("overrun cycle", nth_ev(s, 2, 0, 0), r + 155);
        check("overrun write count", count_kind(s, 0), 0);
        check("overrun keeps data", int'(rx_data), 'h42);

        // Reset during data bit 4
        s = ev_cyc.size();
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'(8'h5A >> i));
        line = 1'b1;
        wait_cycles(8);
        rst = 1'b1;
        wait_cycles(1);
        rst = 1'b0;
        check("midreset rx_data", int'(rx_data), 0);
        check("midreset busy", int'(busy), 0);
        wait_cycles(200);
        check("midreset no events", ev_cyc.size() - s, 0);
        send_frame(8'h99, 1'b1, r);
        wait_cycles(20);
        check("after reset data", nth_ev(s, 0, 0, 1), 'h99);

        // Random traffic, checked by the per-cycle model
        for (int it = 0; it < 60; it++) begin
            int kind;
            kind = int'($urandom_range(0, 9));
            fifo_full = ($urandom_range(0, 3) == 0);
            if (kind == 0) begin
                line = 1'b0;
                wait_cycles(int'($urandom_range(1, 14)));
                line = 1'b1;
            end else if (kind == 1) begin
                send_frame(8'($urandom), 1'b0, r);
                wait_cycles(int'($urandom_range(0, 3 * CPB)));
                line = 1'b1;
            end else if (kind == 2) begin
                line = 1'b0;
                wait_cycles(int'($urandom_range(1, 150)));
                rst = 1'b1;
                wait_cycles(1);
                rst = 1'b0;
                wait_cycles(int'($urandom_range(0, 20)));
                line = 1'b1;
            end else begin
                send_frame(8'($urandom), 1'b1, r);
            end
            wait_cycles(int'($urandom_range(0, 30)));
        end
        fifo_full = 1'b0;
        line = 1'b1;
        wait_cycles(12 * CPB);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_deframer.md
# uart_rx_deframer

Asynchronous serial receiver front end. It synchronises the raw `rx_serial_in` line and detects start bits. It samples 8 data bits LSB-first at mid-bit and checks the stop bit. Each good byte is presented as a one-cycle write strobe that drives the RX FIFO write port directly. It replaces free-running bit counting on the RX path with real 8N1 framing, false-start rejection, framing-error and overrun reporting.

## Interface
- `CLKS_PER_BIT`, default 16: clk cycles per serial bit. Must be even and ≥ 4.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `rx_serial_in`  in  1  raw asynchronous serial line; idle high.
- `fifo_full`  in  1  RX FIFO full flag.
- `rx_data`  out  8  last received byte; drives FIFO `data_in`.
- `rx_wr_en`  out  1  one-cycle strobe for a good byte; drives FIFO `wr_en`.
- `frame_err`  out  1  one-cycle pulse when the stop bit samples low.
- `overrun`  out  1  one-cycle pulse when a good byte arrives while `fifo_full`=1; that byte is dropped.
- `busy`  out  1  high in every state except IDLE.

## Operation
- **Synchroniser:** two flops, reset to 1, produce `rx_s`. All decisions use `rx_s` only.
- **Counters and registers:** bit-time counter `cnt`, width `$clog2(CLKS_PER_BIT)`. Bit index `idx`, 3 bits. Shift register `sh`, 8 bits; each sample shifts in at the MSB, then shifts right, so LSB-first order is restored.
- **HALF** = `CLKS_PER_BIT/2`.
- **IDLE:**
  - `rx_s`=0 → START, `cnt`=0.
- **START:**
  - `cnt` increments each cycle.
  - At `cnt`==HALF-1, sample `rx_s`.
  - Sample 0 → DATA, `cnt`=0, `idx`=0.
  - Sample 1 → IDLE (false start; no output pulse).
- **DATA:**
  - At `cnt`==CLKS_PER_BIT-1, shift `rx_s` into `sh` and set `cnt`=0.
  - If `idx`==7 → STOP; otherwise `idx`+1.
- **STOP:**
  - At `cnt`==CLKS_PER_BIT-1, sample `rx_s`.
  - Sample 1 and `fifo_full`=0 → `rx_data`<=`sh`, `rx_wr_en` pulse, → IDLE.
  - Sample 1 and `fifo_full`=1 → `overrun` pulse, `rx_data` unchanged, no `rx_wr_en`, → IDLE.
  - Sample 0 → `frame_err` pulse, no write, → BREAK.
- **BREAK:**
  - Stay until `rx_s`=1, then → IDLE. A held-low line produces exactly one `frame_err`.
- **Mutual exclusion:** `rx_wr_en`, `frame_err` and `overrun` are mutually exclusive and each is high for exactly one cycle per frame.
- **Reset values:**
  - `rx_data`=8'h00; `rx_wr_en`, `frame_err`, `overrun`, `busy`=0.
  - State IDLE; `cnt`, `idx`, `sh`=0; synchroniser flops=1.
- **Reset mid-frame:** the partial byte is discarded and nothing is emitted. After reset releases, a line that is still low is treated as a new start.

## Timing
- Raw falling edge on `rx_serial_in` in cycle r → `rx_s`=0 at cycle r+2 (cycle e).
- START is entered at e+1.
- Sample points:
  - start-bit check: e+HALF
  - data bit k (k=0..7): e+HALF+(k+1)·CLKS_PER_BIT
  - stop bit: e+HALF+9·CLKS_PER_BIT
- `rx_wr_en`, `frame_err` or `overrun` are registered and assert one cycle after the stop sample: e+HALF+9·CLKS_PER_BIT+1. With the default of 16 this is e+153.
- IDLE is re-entered in the same cycle the strobe is high.
  - A next start seen in that cycle enters START one cycle later.
  - Back-to-back frames with a full-length stop bit are received without loss.
- `fifo_full` is sampled only in the stop-sample cycle. The FIFO updates `full` after a write, so this is sufficient.
- `busy` rises at e+1 and falls in the strobe cycle.

## Structure
- Shared package `uart_pkg`:
  - state enum `rx_state_t` {IDLE, START, DATA, STOP, BREAK}
  - constant `UART_DATA_BITS`=8, shared with the future TX framer
- Sub-module `sync_2ff`: a 1-bit two-flop synchroniser with a reset value parameter. Reused for every async input in the design.
- Expected size: ~150 lines of RTL excluding the package.

## Test plan
- Default parameters. Send 0xA5 as 8N1 at 16 clk/bit, starting in cycle r → `rx_wr_en` exactly once at r+155, `rx_data`=0xA5, no `frame_err` or `overrun`.
- Three frames back-to-back: 0x00, 0xFF, 0x3C, with a 1-bit stop and no idle gap → three `rx_wr_en` pulses, in that order, with those values.
- Line low for 6 clk, then high (glitch) → no output pulse, `busy` back to 0 by r+2+8+1. A following 0x55 frame is received correctly.
- Frame 0x81 with stop bit 0, then line held low for 40 bit-times → exactly one `frame_err`, no `rx_wr_en`. Then line released, and a 0x42 frame is received.
- `fifo_full`=1 during a 0x7E frame → one `overrun`, no `rx_wr_en`, `rx_data` keeps its previous value.
- Assert `rst` for 1 cycle during data bit 4 of a frame → all outputs 0, no strobe for that frame. A clean 0x99 frame sent afterwards is received.
